// File: rtl/latch_bank_ctrl_pkg.sv
// rtl/latch_bank_ctrl_pkg.sv - shared state encodings, default sizes and arbitration helper
`ifndef LATCH_BANK_CTRL_PKG_SV
`define LATCH_BANK_CTRL_PKG_SV
package latch_bank_ctrl_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GRANT  = 2'b01,
      ST_ACCESS = 2'b10,
      ST_ACK    = 2'b11
   } state_e;

   // Returns the winning requester index; on a tie the one not granted last wins.
   function automatic logic pick_winner(input logic req0, input logic req1, input logic last);
      if (req0 && req1) begin
         return ~last;
      end
      return ~req0;
   endfunction

endpackage
`endif

// File: rtl/latch_bank_ctrl_if.sv
// rtl/latch_bank_ctrl_if.sv - two-requester req/gnt/ack bus with master and slave views
interface latch_bank_ctrl_if
   import latch_bank_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) ();

   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              ack;
   logic [DATA_W-1:0] rdata;
   logic              busy;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, ack, rdata, busy
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, ack, rdata, busy
   );

endinterface

// File: rtl/latch_bank_ctrl_word_reg.sv
// rtl/latch_bank_ctrl_word_reg.sv - one storage word with load-enable mux and async clear
module word_reg
   import latch_bank_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d = din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign dout = data_q;

endmodule

// File: rtl/latch_bank_ctrl.sv
// rtl/latch_bank_ctrl.sv - arbitrated two-port controller for a flip-flop word bank
// RR_ARB_EN: defined = round-robin tie-break, undefined = requester 0 always wins a tie.
module latch_bank_ctrl
   import latch_bank_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   latch_bank_ctrl_if.slave bus
);

   localparam int DEPTH = 2**ADDR_W;

   state_e            state_q;
   state_e            state_d;
   logic              win_q;
   logic              win_d;
   logic              lat_we_q;
   logic              lat_we_d;
   logic [ADDR_W-1:0] lat_addr_q;
   logic [ADDR_W-1:0] lat_addr_d;
   logic [DATA_W-1:0] lat_wdata_q;
   logic [DATA_W-1:0] lat_wdata_d;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   logic              any_req;
   logic              accept;
   logic              arb_win;
   logic              last_ptr;
   logic [DEPTH-1:0]  word_load;
   logic [DATA_W-1:0] word_dout [DEPTH];

   assign any_req = bus.req0 | bus.req1;
   assign accept  = (state_q == ST_IDLE) && any_req;

`ifdef RR_ARB_EN
   logic last_q;
   logic last_d;

   always_comb begin
      last_d = last_q;
      if (accept) begin
         last_d = arb_win;
      end
   end

   // Pointer resets to requester 1 so requester 0 takes the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

   assign last_ptr = last_q;
`else
   assign last_ptr = 1'b1;
`endif

   assign arb_win = pick_winner(bus.req0, bus.req1, last_ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (any_req) state_d = ST_GRANT;
         ST_GRANT:  state_d = ST_ACCESS;
         ST_ACCESS: state_d = ST_ACK;
         ST_ACK:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.gnt0  = (state_q != ST_IDLE) && !win_q;
      bus.gnt1  = (state_q != ST_IDLE) && win_q;
      bus.ack   = (state_q == ST_ACK);
      bus.busy  = (state_q != ST_IDLE);
      bus.rdata = rdata_q;
   end

   // Payload is captured only when a request is accepted; later input changes are ignored.
   always_comb begin
      win_d       = win_q;
      lat_we_d    = lat_we_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      if (accept) begin
         win_d       = arb_win;
         lat_we_d    = arb_win ? bus.we1    : bus.we0;
         lat_addr_d  = arb_win ? bus.addr1  : bus.addr0;
         lat_wdata_d = arb_win ? bus.wdata1 : bus.wdata0;
      end
   end

   always_comb begin
      word_load = '0;
      if ((state_q == ST_GRANT) && lat_we_q) begin
         word_load[lat_addr_q] = 1'b1;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (state_q == ST_ACCESS) begin
         rdata_d = word_dout[lat_addr_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q       <= 1'b0;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         win_q       <= win_d;
         lat_we_q    <= lat_we_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      word_reg #(
         .DATA_W (DATA_W)
      ) u_word (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (word_load[i]),
         .din   (lat_wdata_q),
         .dout  (word_dout[i])
      );
   end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// tb/tb_latch_bank_ctrl.sv - directed self-checking bench for latch_bank_ctrl
module tb_latch_bank_ctrl;
   import latch_bank_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   latch_bank_ctrl_if #(.DATA_W(8), .ADDR_W(2)) bus ();

   latch_bank_ctrl #(.DATA_W(8), .ADDR_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
      bus.addr0 = 2'd0; bus.addr1 = 2'd0; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic run_txn(input bit p, input bit we, input logic [1:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output bit got_ack, output int who);
      got_ack = 1'b0;
      rd      = 8'h00;
      if (p) begin
         bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
      end else begin
         bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
      end
      step();
      who = (bus.gnt0 && !bus.gnt1) ? 0 : ((bus.gnt1 && !bus.gnt0) ? 1 : -1);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      for (int i = 0; i < 8 && !got_ack; i++) begin
         step();
         if (bus.ack === 1'b1) begin
            got_ack = 1'b1;
            rd      = bus.rdata;
         end
      end
      step();
   endtask

   task automatic test_reset();
      logic [7:0] rd;
      bit         got;
      int         who;
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) step();
      checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b expected 0", bus.gnt0); end
      checks++; if (bus.gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b expected 0", bus.gnt1); end
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus.ack); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", bus.rdata); end
      rst_n = 1'b1;
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL release_busy: got %b expected 0", bus.busy); end
      run_txn(1'b0, 1'b0, 2'd3, 8'h00, rd, got, who);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL reset_read_ack: got %b expected 1", got); end
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_read_addr3: got %h expected 00", rd); end
   endtask

   task automatic test_write_read();
      logic [7:0] rd;
      bit         got;
      int         who;
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd2; bus.wdata0 = 8'hA5;
      step();
      bus.req0 = 1'b0;
      checks++; if (bus.gnt0 !== 1'b1) begin errors++; $display("FAIL wr_gnt0_e0: got %b expected 1", bus.gnt0); end
      checks++; if (bus.gnt1 !== 1'b0) begin errors++; $display("FAIL wr_gnt1_e0: got %b expected 0", bus.gnt1); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wr_busy_e0: got %b expected 1", bus.busy); end
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL wr_ack_e0: got %b expected 0", bus.ack); end
      step();
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL wr_ack_e1: got %b expected 0", bus.ack); end
      step();
      checks++; if (bus.ack !== 1'b1) begin errors++; $display("FAIL wr_ack_e2: got %b expected 1", bus.ack); end
      checks++; if (bus.rdata !== 8'hA5) begin errors++; $display("FAIL wr_rdata_e2: got %h expected a5", bus.rdata); end
      checks++; if (bus.gnt0 !== 1'b1) begin errors++; $display("FAIL wr_gnt0_e2: got %b expected 1", bus.gnt0); end
      step();
      checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL wr_ack_e3: got %b expected 0", bus.ack); end
      checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL wr_gnt0_e3: got %b expected 0", bus.gnt0); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_busy_e3: got %b expected 0", bus.busy); end
      run_txn(1'b1, 1'b0, 2'd2, 8'h00, rd, got, who);
      checks++; if (who !== 1) begin errors++; $display("FAIL rd1_winner: got %0d expected 1", who); end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL rd1_ack: got %b expected 1", got); end
      checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL rd1_data: got %h expected a5", rd); end
   endtask

   task automatic test_tie();
      int acks;
      int who_q [8];
      int cyc_q [8];
      int exp_who [4];
      bit gnt1_seen;
`ifdef RR_ARB_EN
      exp_who = '{0, 1, 0, 1};
`else
      exp_who = '{0, 0, 0, 0};
`endif
      idle_inputs();
      apply_reset();
      acks      = 0;
      gnt1_seen = 1'b0;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      bus.addr0 = 2'd0; bus.addr1 = 2'd1;
      for (int c = 1; c <= 16; c++) begin
         step();
         if (bus.gnt1 === 1'b1) gnt1_seen = 1'b1;
         if (bus.ack === 1'b1 && acks < 8) begin
            who_q[acks] = bus.gnt1 ? 1 : 0;
            cyc_q[acks] = c;
            acks++;
         end
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      step();
      step();
      checks++; if (acks !== 4) begin errors++; $display("FAIL tie_ack_count: got %0d expected 4", acks); end
      for (int k = 0; k < 4 && k < acks; k++) begin
         checks++; if (who_q[k] !== exp_who[k]) begin errors++; $display("FAIL tie_order[%0d]: got %0d expected %0d", k, who_q[k], exp_who[k]); end
         checks++; if (cyc_q[k] !== 3 + 4*k) begin errors++; $display("FAIL tie_ack_cycle[%0d]: got %0d expected %0d", k, cyc_q[k], 3 + 4*k); end
      end
`ifndef RR_ARB_EN
      checks++; if (gnt1_seen !== 1'b0) begin errors++; $display("FAIL fixed_gnt1_never: got %b expected 0", gnt1_seen); end
`endif
   endtask

   task automatic test_payload_hold();
      logic [7:0] rd;
      bit         got;
      int         who;
      got = 1'b0;
      rd  = 8'h00;
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd1; bus.wdata0 = 8'h3C;
      step();
      checks++; if (bus.gnt0 !== 1'b1) begin errors++; $display("FAIL hold_gnt0: got %b expected 1", bus.gnt0); end
      bus.wdata0 = 8'hFF;
      bus.req0   = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         step();
         if (bus.ack === 1'b1) begin got = 1'b1; rd = bus.rdata; end
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL hold_ack: got %b expected 1", got); end
      checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL hold_rdata: got %h expected 3c", rd); end
      step();
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_no_retrigger: got %b expected 0", bus.busy); end
      run_txn(1'b1, 1'b0, 2'd1, 8'h00, rd, got, who);
      checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL hold_readback: got %h expected 3c", rd); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] rd;
      bit         got;
      int         who;
      bit         ack_seen;
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd3; bus.wdata0 = 8'h99;
      step();
      bus.req0 = 1'b0;
      step();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_access: got %b expected 1", bus.busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL mid_gnt0: got %b expected 0", bus.gnt0); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL mid_rdata: got %h expected 00", bus.rdata); end
      ack_seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.ack !== 1'b0) ack_seen = 1'b1;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.ack !== 1'b0) ack_seen = 1'b1;
      end
      checks++; if (ack_seen !== 1'b0) begin errors++; $display("FAIL mid_no_ack: got %b expected 0", ack_seen); end
      run_txn(1'b0, 1'b0, 2'd3, 8'h00, rd, got, who);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL mid_readback3: got %h expected 00", rd); end
      run_txn(1'b0, 1'b0, 2'd1, 8'h00, rd, got, who);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL mid_readback1: got %h expected 00", rd); end
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_write_read();
      test_tie();
      test_payload_hold();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
